// File: rtl/prog_mem_responder.sv
// Per-node program store: streams a program in over a valid/ready loader
// port and serves zero-latency instruction fetches once a full program is in.
// Ports: clk, reset (async, active-high); loader: load_start, load_valid,
//   load_data, load_last, load_ready; fetch: Addr_instr, instr, instr_valid;
//   status: prog_len, core_run; parity_err only when PARITY_EN is defined.
// Optional feature macro: PARITY_EN (per-word even parity, sticky error).
module prog_mem_responder #(
  parameter int          DEPTH     = 16,
  parameter int          AW        = 8,
  parameter int          IW        = 18,
  parameter int          LW        = 5,
  parameter logic [IW-1:0] FILL_WORD = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic [AW-1:0] Addr_instr,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  output logic [LW-1:0] prog_len,
  output logic          core_run
`ifdef PARITY_EN
  ,
  output logic          parity_err
`endif
);

  localparam int IXW = $clog2(DEPTH);
`ifdef PARITY_EN
  localparam int MW = IW + 1;
`else
  localparam int MW = IW;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] wp, wp_nxt, len_nxt;
  logic          we;
  logic [MW-1:0] wdata;
  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] word;
  logic          fetch_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wp       <= '0;
      prog_len <= '0;
    end else begin
      state    <= state_nxt;
      wp       <= wp_nxt;
      prog_len <= len_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wp_nxt     = wp;
    len_nxt    = prog_len;
    we         = 1'b0;
    load_ready = 1'b0;
    core_run   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_start) begin
          state_nxt = LOAD;
          wp_nxt    = '0;
          len_nxt   = '0;
        end
      end
      LOAD: begin
        load_ready = (wp < LW'(DEPTH));
        // A restart wins over any word presented in the same cycle.
        if (load_start) begin
          wp_nxt  = '0;
          len_nxt = '0;
        end else if (load_valid && load_ready) begin
          we     = 1'b1;
          wp_nxt = wp + LW'(1);
          if (load_last || (wp == LW'(DEPTH - 1))) begin
            state_nxt = RUN;
            len_nxt   = wp + LW'(1);
          end
        end
      end
      RUN: begin
        core_run = 1'b1;
        if (load_start) begin
          state_nxt = LOAD;
          wp_nxt    = '0;
          len_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PARITY_EN
  assign wdata = {^load_data, load_data};
`else
  assign wdata = load_data;
`endif

  always_ff @(posedge clk) begin
    if (we) mem[wp[IXW-1:0]] <= wdata;
  end

  // prog_len <= DEPTH, so a valid fetch always indexes inside the array.
  assign fetch_ok    = (state == RUN) && (Addr_instr < AW'(prog_len));
  assign word        = mem[Addr_instr[IXW-1:0]];
  assign instr       = fetch_ok ? word[IW-1:0] : FILL_WORD;
  assign instr_valid = fetch_ok;

`ifdef PARITY_EN
  // Stored bit makes the whole word even; any odd result is a corruption.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_err <= 1'b0;
    end else if (load_start) begin
      parity_err <= 1'b0;
    end else if (fetch_ok && (^word)) begin
      parity_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/prog_mem_responder.md
Name: prog_mem_responder

Overview:
- Per-node program store that answers the fetch side of the TIS-100 node datapath.
- Accepts an 8-bit fetch address (Addr_instr) and returns the 18-bit instruction word in the same cycle.
- A valid/ready loader port streams a program in word by word.
- A small FSM (IDLE/LOAD/RUN) gates node execution until a complete program has been loaded.

Parameters:
- DEPTH, 16, number of instruction slots; TIS-100 node limit is 15, one spare.
- AW, 8, fetch address width; matches the IP register.
- IW, 18, instruction word width.
- LW, 5, width of the prog_len count; must hold 0..DEPTH.
- FILL_WORD, 18'h00000, word returned for any non-valid fetch.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  single-cycle pulse; begins a new program load.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  IW  instruction word to store.
- load_last  in  1  qualifies load_data as the final word of the program.
- load_ready  out  1  store can accept a word this cycle.
- Addr_instr  in  AW  fetch address from the IP register.
- instr  out  IW  fetched instruction; combinational from Addr_instr.
- instr_valid  out  1  instr holds a loaded word.
- prog_len  out  LW  number of words loaded.
- core_run  out  1  node may execute; high only in RUN.

Behaviour:
Reset (asynchronous, active-high; all values immediate):
- state=IDLE, write pointer wp=0, prog_len=0, load_ready=0, core_run=0, instr=FILL_WORD, instr_valid=0.
- Storage contents are not cleared and are don't-care.

States:
- IDLE: load_start -> LOAD with wp=0, prog_len=0.
- LOAD: load_ready=1 while wp<DEPTH.
  - A word is accepted on a cycle with load_valid & load_ready: mem[wp]<=load_data, wp<=wp+1.
  - If the accepted word has load_last=1, or it is the word at wp=DEPTH-1: next state RUN, prog_len<=wp+1.
  - load_valid with load_ready=0 is ignored.
  - load_last on a cycle without load_valid is ignored.
- RUN: core_run=1, load_ready=0.
  - load_start -> LOAD. core_run drops the next cycle; wp=0 and prog_len=0 take effect on that same edge.
- load_start while already in LOAD restarts the load: wp=0, prog_len=0. Any word presented in the same cycle is dropped; load_start has priority.

Fetch (combinational, zero latency):
- Valid fetch requires state==RUN and Addr_instr<prog_len. Then instr=mem[Addr_instr] and instr_valid=1.
- Every other case gives instr=FILL_WORD and instr_valid=0. This covers IDLE, LOAD, and RUN with Addr_instr>=prog_len, including Addr_instr>=DEPTH.
- The fetch port never wraps addresses. Sequencing back to address 0 is the jump path's job.

Width rules:
- Compare Addr_instr against prog_len zero-extended to AW bits.
- wp is LW bits wide and never exceeds DEPTH.

Writes:
- Writes happen only in LOAD, so a fetch never observes a partially written program.

Optional Feature:
PARITY_EN
- Defined:
  - Each stored word gets an extra even-parity bit computed on write.
  - A valid fetch recomputes parity. A mismatch sets a sticky output parity_err (1 bit).
  - parity_err is cleared by reset or load_start.
  - A mismatched fetch still returns the stored word.
- Undefined:
  - No parity storage and no parity_err port.
  - Behaviour is otherwise identical.

Test Plan:
1. Reset mid-LOAD after 3 words accepted -> same cycle: core_run=0, load_ready=0, prog_len=0, instr=18'h00000. After release, state is IDLE and load_ready stays 0 until load_start.
2. load_start, then 4 words 18'h10001..18'h10004 with load_last on the 4th -> prog_len=4 and core_run=1 one cycle after the 4th accept. Addr_instr=2 gives instr=18'h10003 with instr_valid=1. Addr_instr=4 gives 18'h00000 with instr_valid=0.
3. Stream 20 words without load_last -> exactly 16 accepted and load_ready=0 after the 16th. prog_len=16, RUN entered. Addr_instr=15 returns the 16th word. Addr_instr=8'hFF returns FILL_WORD.
4. In RUN with prog_len=4, pulse load_start -> core_run=0 next cycle. Fetch of Addr_instr=0 during LOAD returns FILL_WORD/instr_valid=0. Reload 2 words gives prog_len=2.
5. In LOAD after 2 words, assert load_start together with load_valid=1 and data 18'h3FFFF -> word dropped, wp=0. The next accepted word lands at address 0.
6. PARITY_EN: force a stored bit flip, then fetch that address in RUN -> parity_err=1 and stays 1 across later good fetches. load_start clears it.
